sub_const_pipe: RTL and testbench

//   Parametrised pipelined constant subtractor: diff = min - SUBTRAHEND - bin, mod 2^WIDTH.
//   The borrow chain is split into STAGES segments with a registered borrow between them.

---
 rtl/sub_const_pipe.sv | 118 +++++++++++
 tb/tb_sub_const_pipe.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_const_pipe.sv
// rtl/sub_const_pipe.sv - pipelined constant subtractor, diff = min - SUBTRAHEND - bin mod 2^WIDTH
//
// The borrow chain is cut into STAGES segments of SEG = ceil(WIDTH/STAGES) bits,
// with a registered borrow between neighbouring segments. Each stage register holds
// one full WIDTH-bit word: low bits are already-computed result bits, high bits are
// still-raw minuend bits waiting for their segment. This way the raw bits are skewed
// forward and the finished bits are delayed, so everything leaves the last stage aligned.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input operand valid
//   in_ready   block accepts input this cycle (= global advance enable)
//   min        minuend, WIDTH bits
//   bin        borrow-in, weight 1
//   out_valid  diff/bout valid
//   out_ready  downstream accepts output
//   diff       result, WIDTH bits (forced to 0 on underflow when SATURATE=1)
//   bout       borrow out of the MSB (1 = min < SUBTRAHEND + bin)
module sub_const_pipe #(
    parameter int                WIDTH      = 9,
    parameter logic [WIDTH-1:0]  SUBTRAHEND = WIDTH'(9'h07F),
    parameter int                STAGES     = 3,
    parameter bit                SATURATE   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] min,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int SEG = (WIDTH + STAGES - 1) / STAGES;

    logic [WIDTH-1:0] data_q  [STAGES];
    logic             bor_q   [STAGES];
    logic             valid_q [STAGES];

    logic [WIDTH-1:0] nxt_data  [STAGES];
    logic             nxt_bor   [STAGES];
    logic             nxt_valid [STAGES];

    logic adv;

    // Whole pipe moves together: it may advance whenever the output slot is free
    // or being emptied this cycle. Bubbles are not squeezed out during a stall.
    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Bit range [LO, HI) handled by this stage; empty when ceil() leaves
        // nothing for trailing stages, in which case the stage is a plain delay.
        localparam int LO = k * SEG;
        localparam int HI = ((k + 1) * SEG > WIDTH) ? WIDTH : (k + 1) * SEG;

        logic [WIDTH-1:0] src_data;
        logic             src_bor;
        logic             src_valid;
        logic [WIDTH-1:0] work_data;
        logic             work_bor;

        if (k == 0) begin : g_src
            assign src_data  = min;
            assign src_bor   = bin;
            assign src_valid = in_valid & in_ready;
        end else begin : g_src
            assign src_data  = data_q[k-1];
            assign src_bor   = bor_q[k-1];
            assign src_valid = valid_q[k-1];
        end

        always_comb begin
            work_data = src_data;
            work_bor  = src_bor;
            for (int i = 0; i < WIDTH; i++) begin
                if (i >= LO && i < HI) begin
                    work_data[i] = src_data[i] ^ SUBTRAHEND[i] ^ work_bor;
                    work_bor     = (~src_data[i] & SUBTRAHEND[i])
                                 | (~(src_data[i] ^ SUBTRAHEND[i]) & work_bor);
                end
            end
            // Saturation is applied only where the final borrow is known.
            if (k == STAGES - 1 && SATURATE && work_bor) begin
                work_data = '0;
            end
        end

        assign nxt_data[k]  = work_data;
        assign nxt_bor[k]   = work_bor;
        assign nxt_valid[k] = src_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                data_q[k]  <= '0;
                bor_q[k]   <= 1'b0;
                valid_q[k] <= 1'b0;
            end
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                data_q[k]  <= nxt_data[k];
                bor_q[k]   <= nxt_bor[k];
                valid_q[k] <= nxt_valid[k];
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign diff      = data_q[STAGES-1];
    assign bout      = bor_q[STAGES-1];

endmodule

// File: tb/tb_sub_const_pipe.sv
// tb/tb_sub_const_pipe.sv - scoreboard bench for sub_const_pipe (default, saturating and wide configs)
module tb_sub_const_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // default configuration: WIDTH=9, SUBTRAHEND=0x07F, STAGES=3, SATURATE=0
    logic       a_vld = 0, a_bin = 0, a_ordy = 1;
    logic [8:0] a_min = '0;
    logic       a_irdy, a_ovld, a_bout;
    logic [8:0] a_diff;

    sub_const_pipe u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(a_vld), .in_ready(a_irdy), .min(a_min), .bin(a_bin),
        .out_valid(a_ovld), .out_ready(a_ordy), .diff(a_diff), .bout(a_bout)
    );

    // saturating variant shares the operand wires
    logic       s_vld = 0, s_ordy = 1;
    logic       s_irdy, s_ovld, s_bout;
    logic [8:0] s_diff;

    sub_const_pipe #(.SATURATE(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(s_vld), .in_ready(s_irdy), .min(a_min), .bin(a_bin),
        .out_valid(s_ovld), .out_ready(s_ordy), .diff(s_diff), .bout(s_bout)
    );

    // wide variant: WIDTH=16, STAGES=5, SUBTRAHEND=0x3FF
    logic        w_vld = 0, w_bin = 0, w_ordy = 1;
    logic [15:0] w_min = '0;
    logic        w_irdy, w_ovld, w_bout;
    logic [15:0] w_diff;

    sub_const_pipe #(.WIDTH(16), .SUBTRAHEND(16'h03FF), .STAGES(5)) u_wide (
        .clk(clk), .rst_n(rst_n), .in_valid(w_vld), .in_ready(w_irdy), .min(w_min), .bin(w_bin),
        .out_valid(w_ovld), .out_ready(w_ordy), .diff(w_diff), .bout(w_bout)
    );

    logic [9:0]  qa [$];
    logic [9:0]  qs [$];
    logic [16:0] qw [$];

    int  w_xfers = 0;
    bit  stream_mode = 0;

    function automatic logic [16:0] wmodel(input logic [15:0] m, input logic b);
        return {1'b0, m} - 17'h003FF - 17'(b);
    endfunction

    // monitor for the default DUT: pops on every output transfer, checks stall hold
    logic       a_stall_prev = 0;
    logic [8:0] a_diff_prev  = '0;
    logic       a_bout_prev  = 0;
    always @(negedge clk) begin
        logic [9:0] e;
        if (!rst_n) begin
            a_stall_prev = 0;
        end else begin
            if (a_stall_prev) begin
                chk("stall_hold_valid", 32'(a_ovld), 32'd1);
                chk("stall_hold_diff", 32'(a_diff), 32'(a_diff_prev));
                chk("stall_hold_bout", 32'(a_bout), 32'(a_bout_prev));
            end
            if (a_ovld && !a_ordy) chk("stall_in_ready", 32'(a_irdy), 32'd0);
            if (stream_mode) chk("stream_in_ready", 32'(a_irdy), 32'd1);
            if (a_ovld && a_ordy) begin
                if (qa.size() == 0) chk("a_spurious_out", 32'(a_ovld), 32'd0);
                else begin
                    e = qa.pop_front();
                    chk("a_diff", 32'(a_diff), 32'(e[8:0]));
                    chk("a_bout", 32'(a_bout), 32'(e[9]));
                end
            end
            a_stall_prev = a_ovld && !a_ordy;
            a_diff_prev  = a_diff;
            a_bout_prev  = a_bout;
        end
    end

    always @(negedge clk) begin
        logic [9:0] e;
        if (rst_n && s_ovld && s_ordy) begin
            if (qs.size() == 0) chk("s_spurious_out", 32'(s_ovld), 32'd0);
            else begin
                e = qs.pop_front();
                chk("s_diff", 32'(s_diff), 32'(e[8:0]));
                chk("s_bout", 32'(s_bout), 32'(e[9]));
            end
        end
    end

    always @(negedge clk) begin
        logic [16:0] e;
        if (rst_n) begin
            if (w_vld && w_irdy) begin
                qw.push_back(wmodel(w_min, w_bin));
                w_xfers++;
            end
            if (w_ovld && w_ordy) begin
                if (qw.size() == 0) chk("w_spurious_out", 32'(w_ovld), 32'd0);
                else begin
                    e = qw.pop_front();
                    chk("w_diff", 32'(w_diff), 32'(e[15:0]));
                    chk("w_bout", 32'(w_bout), 32'(e[16]));
                end
            end
        end
    end

    // Present one operand on the default DUT and hold it until accepted; the
    // expected result is queued at the moment of acceptance.
    task automatic send(input logic [8:0] m, input logic b, input logic [8:0] ed, input logic eb);
        bit done = 0;
        a_vld = 1; a_min = m; a_bin = b;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            if (a_irdy) begin
                qa.push_back({eb, ed});
                done = 1;
            end
            @(posedge clk); #1;
        end
        if (!done) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_s(input logic [8:0] m, input logic b, input logic [8:0] ed, input logic eb);
        s_vld = 1; a_min = m; a_bin = b;
        @(negedge clk);
        if (s_irdy) qs.push_back({eb, ed});
        else chk("send_s_ready", 32'(s_irdy), 32'd1);
        @(posedge clk); #1;
        s_vld = 0;
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(a_ovld), 32'd0);
        chk("rst_diff", 32'(a_diff), 32'd0);
        chk("rst_bout", 32'(a_bout), 32'd0);
        rst_n = 1;
        #1;
        chk("rst_in_ready", 32'(a_irdy), 32'd1);
        @(posedge clk); #1;

        // 1: latency is exactly 3 cycles, single-cycle valid
        send(9'h100, 0, 9'h081, 0);
        a_vld = 0;
        @(negedge clk); chk("lat_c1", 32'(a_ovld), 32'd0);
        @(negedge clk); chk("lat_c2", 32'(a_ovld), 32'd0);
        @(negedge clk); chk("lat_c3", 32'(a_ovld), 32'd1);
        @(negedge clk); chk("lat_c4", 32'(a_ovld), 32'd0);
        @(posedge clk); #1;

        // 2: boundary cases
        send(9'h07F, 0, 9'h000, 0);
        send(9'h07F, 1, 9'h1FF, 1);
        send(9'h000, 0, 9'h181, 1);
        send(9'h1FF, 1, 9'h17F, 0);
        a_vld = 0;
        repeat (6) @(posedge clk); #1;

        // 4: gapless stream 0x080..0x08F -> 0x001..0x010 on consecutive cycles
        stream_mode = 1;
        fork
            begin
                for (int i = 0; i < 16; i++) send(9'h080 + 9'(i), 0, 9'h001 + 9'(i), 0);
                a_vld = 0;
            end
            begin
                int t = 0;
                @(negedge clk);
                while (!a_ovld && t < 10) begin @(negedge clk); t++; end
                for (int i = 0; i < 16; i++) begin
                    chk("stream_consecutive", 32'(a_ovld), 32'd1);
                    @(negedge clk);
                end
            end
        join
        stream_mode = 0;
        repeat (5) @(posedge clk); #1;

        // 5: 8 inputs with a 5-cycle downstream stall in the middle
        fork
            begin
                for (int i = 0; i < 8; i++) send(9'h090 + 9'(i), 0, 9'h011 + 9'(i), 0);
                a_vld = 0;
            end
            begin
                repeat (3) @(posedge clk); #1;
                a_ordy = 0;
                repeat (5) @(posedge clk); #1;
                a_ordy = 1;
            end
        join
        repeat (12) @(posedge clk); #1;
        chk("stall_drained", 32'(qa.size()), 32'd0);

        // 6: reset with two transactions in flight
        send(9'h100, 0, 9'h081, 0);
        send(9'h101, 0, 9'h082, 0);
        a_vld = 0;
        rst_n = 0;
        #1;
        chk("midrst_out_valid", 32'(a_ovld), 32'd0);
        chk("midrst_diff", 32'(a_diff), 32'd0);
        qa.delete();
        @(posedge clk); #1;
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midrst_no_stale", 32'(a_ovld), 32'd0);
        end
        @(posedge clk); #1;
        send(9'h17F, 0, 9'h100, 0);
        a_vld = 0;
        repeat (5) @(posedge clk); #1;

        // 3: saturating variant
        send_s(9'h000, 0, 9'h000, 1);
        send_s(9'h0FF, 0, 9'h080, 0);
        send_s(9'h07F, 1, 9'h000, 1);
        repeat (5) @(posedge clk); #1;

        // wide variant under random valid/ready
        begin
            int cyc = 0;
            while (w_xfers < 10000 && cyc < 40000) begin
                w_vld  = ($urandom_range(0, 3) != 0);
                w_min  = 16'($urandom);
                w_bin  = 1'($urandom);
                w_ordy = ($urandom_range(0, 3) != 0);
                @(posedge clk); #1;
                cyc++;
            end
            chk("wide_xfer_count", 32'(w_xfers >= 10000), 32'd1);
        end
        w_vld = 0;
        w_ordy = 1;

        begin
            int t = 0;
            while ((qa.size() != 0 || qs.size() != 0 || qw.size() != 0) && t < 200) begin
                @(posedge clk); #1; t++;
            end
        end
        chk("drain_a", 32'(qa.size()), 32'd0);
        chk("drain_s", 32'(qs.size()), 32'd0);
        chk("drain_w", 32'(qw.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
